// File: rtl/fixpoint_pkg.sv
// Shared definitions for the fixpoint iteration block: controller states and
// the width rule for the iteration counter.
package fixpoint_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_e;

    // Bits needed to count 0..max_iter inclusive; never narrower than one bit.
    function automatic int iter_width(input int max_iter);
        if (max_iter < 1) begin
            return 1;
        end
        return $clog2(max_iter + 1);
    endfunction

endpackage

// File: rtl/fixpoint_step.sv
// One propagation step around the channel ring: each channel keeps its bit and
// may additionally pick up its neighbour's bit when enabled and not blocked.
module fixpoint_step #(
    parameter int NCH = 5
) (
    input  logic [NCH-1:0] s,
    input  logic [NCH-1:0] req,
    input  logic [NCH-1:0] blk,
    input  logic           dir,
    output logic [NCH-1:0] next
);

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            localparam int PREV = (gi + NCH - 1) % NCH;
            localparam int SUCC = (gi + 1) % NCH;

            logic src_bit;

            assign src_bit  = dir ? s[SUCC] : s[PREV];
            assign next[gi] = s[gi] | (src_bit & req[gi] & ~blk[gi]);
        end
    endgenerate

endmodule

// File: rtl/fixpoint_iter.sv
// Iterates the ring step from a loaded state until it stops changing or the
// iteration budget runs out, then publishes the result with a one-cycle done.
module fixpoint_iter
    import fixpoint_pkg::*;
#(
    parameter int NCH      = 5,
    parameter int MAX_ITER = NCH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          dir,
    input  logic [NCH-1:0]                init_state,
    input  logic [NCH-1:0]                req,
    input  logic [NCH-1:0]                blk,
    input  logic [NCH-1:0]                bad_mask,
    output logic                          ready,
    output logic                          done,
    output logic [NCH-1:0]                fix_state,
    output logic [iter_width(MAX_ITER)-1:0] iter_cnt,
    output logic                          bug,
    output logic                          timeout
);

    localparam int            IW         = iter_width(MAX_ITER);
    localparam logic [IW-1:0] ITER_LIMIT = IW'(MAX_ITER);

    fsm_state_e     state_q, state_d;

    // Working state of the current run; operands are frozen at start accept.
    logic [NCH-1:0] s_q, s_d;
    logic [IW-1:0]  iter_q, iter_d;
    logic           dir_q, dir_d;
    logic [NCH-1:0] req_q, req_d;
    logic [NCH-1:0] blk_q, blk_d;
    logic [NCH-1:0] bad_q, bad_d;

    // Published result, held until the next run completes.
    logic [NCH-1:0] fix_q, fix_d;
    logic [IW-1:0]  cnt_q, cnt_d;
    logic           bug_q, bug_d;
    logic           to_q, to_d;
    logic           done_q, done_d;

    logic [NCH-1:0] next_s;
    logic           changed;

    fixpoint_step #(
        .NCH (NCH)
    ) u_step (
        .s    (s_q),
        .req  (req_q),
        .blk  (blk_q),
        .dir  (dir_q),
        .next (next_s)
    );

    assign changed = (next_s != s_q);

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        iter_d  = iter_q;
        dir_d   = dir_q;
        req_d   = req_q;
        blk_d   = blk_q;
        bad_d   = bad_q;
        fix_d   = fix_q;
        cnt_d   = cnt_q;
        bug_d   = bug_q;
        to_d    = to_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dir_d   = dir;
                    req_d   = req;
                    blk_d   = blk;
                    bad_d   = bad_mask;
                    s_d     = init_state;
                    iter_d  = '0;
                    state_d = ST_ITER;
                end
            end
            ST_ITER: begin
                if (changed && (iter_q < ITER_LIMIT)) begin
                    s_d    = next_s;
                    iter_d = iter_q + IW'(1);
                end else begin
                    // Either converged, or out of budget with s left as-is.
                    state_d = ST_DONE;
                    fix_d   = s_q;
                    cnt_d   = iter_q;
                    bug_d   = |(s_q & bad_q);
                    to_d    = changed;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            iter_q  <= '0;
            dir_q   <= 1'b0;
            req_q   <= '0;
            blk_q   <= '0;
            bad_q   <= '0;
            fix_q   <= '0;
            cnt_q   <= '0;
            bug_q   <= 1'b0;
            to_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            iter_q  <= iter_d;
            dir_q   <= dir_d;
            req_q   <= req_d;
            blk_q   <= blk_d;
            bad_q   <= bad_d;
            fix_q   <= fix_d;
            cnt_q   <= cnt_d;
            bug_q   <= bug_d;
            to_q    <= to_d;
            done_q  <= done_d;
        end
    end

    assign ready     = (state_q == ST_IDLE);
    assign done      = done_q;
    assign fix_state = fix_q;
    assign iter_cnt  = cnt_q;
    assign bug       = bug_q;
    assign timeout   = to_q;

endmodule

// File: tb/tb_fixpoint_iter.sv
// Directed checks of fixpoint_iter: convergence, blocking, timeout, busy start,
// mid-run reset and the trivial fixpoint cases.
module tb_fixpoint_iter;

    logic       clk;
    logic       rst;
    logic       start;
    logic       start2;
    logic       dir;
    logic [4:0] init_state;
    logic [4:0] req;
    logic [4:0] blk;
    logic [4:0] bad_mask;

    logic       ready,  done,  bug,  timeout;
    logic [4:0] fix_state;
    logic [2:0] iter_cnt;

    logic       ready2, done2, bug2, timeout2;
    logic [4:0] fix_state2;
    logic [1:0] iter_cnt2;

    int checks = 0;
    int errors = 0;

    fixpoint_iter #(.NCH(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dir        (dir),
        .init_state (init_state),
        .req        (req),
        .blk        (blk),
        .bad_mask   (bad_mask),
        .ready      (ready),
        .done       (done),
        .fix_state  (fix_state),
        .iter_cnt   (iter_cnt),
        .bug        (bug),
        .timeout    (timeout)
    );

    fixpoint_iter #(.NCH(5), .MAX_ITER(2)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .start      (start2),
        .dir        (dir),
        .init_state (init_state),
        .req        (req),
        .blk        (blk),
        .bad_mask   (bad_mask),
        .ready      (ready2),
        .done       (done2),
        .fix_state  (fix_state2),
        .iter_cnt   (iter_cnt2),
        .bug        (bug2),
        .timeout    (timeout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Starts a run (sel=1 targets the MAX_ITER=2 instance) from a negedge and
    // returns the number of edges from the accept edge to the done edge.
    task automatic run(input logic sel, input logic [4:0] i_s, input logic [4:0] i_r,
                       input logic [4:0] i_b, input logic [4:0] i_m, input logic i_d,
                       output int lat);
        logic seen;
        init_state = i_s; req = i_r; blk = i_b; bad_mask = i_m; dir = i_d;
        if (sel) start2 = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start2 = 1'b0;
        lat  = 0;
        seen = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(posedge clk); #1;
            if ((sel ? done2 : done) === 1'b1) begin
                lat  = k;
                seen = 1'b1;
            end
        end
        check("ready_low_in_done", sel ? ready2 : ready, 1'b0);
        @(posedge clk); #1;
        check("done_one_cycle", sel ? done2 : done, 1'b0);
        check("ready_back", sel ? ready2 : ready, 1'b1);
        @(negedge clk);
    endtask

    initial begin
        int lat, pulses, first;

        rst = 1'b1; start = 1'b0; start2 = 1'b0; dir = 1'b0;
        init_state = '0; req = '0; blk = '0; bad_mask = '0;
        #3;
        check("rst_ready", ready, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_fix", fix_state, 5'b0);
        check("rst_iter", iter_cnt, 3'd0);
        check("rst_bug", bug, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Full left-to-right propagation: 4 iterations, done 5 edges later.
        run(1'b0, 5'b00001, 5'b11111, 5'b00000, 5'b00000, 1'b0, lat);
        check("fill_lat", lat, 5);
        check("fill_fix", fix_state, 5'b11111);
        check("fill_iter", iter_cnt, 3'd4);
        check("fill_timeout", timeout, 1'b0);

        // Block on channel 2 stops propagation after one step.
        run(1'b0, 5'b00001, 5'b11111, 5'b00100, 5'b10000, 1'b0, lat);
        check("blk_lat", lat, 2);
        check("blk_fix", fix_state, 5'b00011);
        check("blk_iter", iter_cnt, 3'd1);
        check("blk_bug", bug, 1'b0);

        // Already a fixpoint: one edge, zero iterations, bug from bad_mask.
        run(1'b0, 5'b10100, 5'b00000, 5'b00000, 5'b00100, 1'b0, lat);
        check("fixed_lat", lat, 1);
        check("fixed_iter", iter_cnt, 3'd0);
        check("fixed_fix", fix_state, 5'b10100);
        check("fixed_bug1", bug, 1'b1);
        run(1'b0, 5'b10100, 5'b00000, 5'b00000, 5'b01011, 1'b0, lat);
        check("fixed_bug0", bug, 1'b0);

        run(1'b0, 5'b00000, 5'b11111, 5'b00000, 5'b11111, 1'b0, lat);
        check("zero_lat", lat, 1);
        check("zero_fix", fix_state, 5'b0);
        check("zero_bug", bug, 1'b0);

        // Reverse direction: 00001 -> 10001 -> 11001 -> 11101 -> 11111.
        run(1'b0, 5'b00001, 5'b11111, 5'b00000, 5'b00010, 1'b1, lat);
        check("rev_lat", lat, 5);
        check("rev_fix", fix_state, 5'b11111);
        check("rev_iter", iter_cnt, 3'd4);
        check("rev_bug", bug, 1'b1);

        // Budget of 2 runs out before the ring settles.
        run(1'b1, 5'b00001, 5'b11111, 5'b00000, 5'b00000, 1'b1, lat);
        check("to_lat", lat, 3);
        check("to_fix", fix_state2, 5'b11001);
        check("to_iter", iter_cnt2, 2'd2);
        check("to_flag", timeout2, 1'b1);
        check("hold_fix", fix_state, 5'b11111);
        check("hold_iter", iter_cnt, 3'd4);

        // start pulsed again mid-run is ignored.
        init_state = 5'b00001; req = 5'b11111; blk = '0; bad_mask = 5'b11111; dir = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        pulses = 0; first = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 3) start = 1'b1;
            if (k == 4) start = 1'b0;
            @(posedge clk); #1;
            if (done === 1'b1) begin
                pulses++;
                if (first == 0) first = k;
            end
        end
        check("busy_pulses", pulses, 1);
        check("busy_lat", first, 5);
        check("busy_fix", fix_state, 5'b11111);
        check("busy_bug", bug, 1'b1);
        @(negedge clk);

        // Reset in the middle of a run abandons it.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("mrst_ready", ready, 1'b1);
        check("mrst_done", done, 1'b0);
        check("mrst_fix", fix_state, 5'b0);
        check("mrst_iter", iter_cnt, 3'd0);
        check("mrst_bug", bug, 1'b0);
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
        end
        check("mrst_no_done", pulses, 0);
        @(negedge clk);
        run(1'b0, 5'b00001, 5'b11111, 5'b00000, 5'b00000, 1'b0, lat);
        check("post_rst_lat", lat, 5);
        check("post_rst_fix", fix_state, 5'b11111);
        check("post_rst_iter", iter_cnt, 3'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
